// File: rtl/led_driver_pkg.sv
// Shared definitions for the LED driver: FSM state encoding, mode codes,
// the default prescaler length and the phase-length helper.
package led_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'b00,
        MODE_BLINK    = 2'b01,
        MODE_STRETCH  = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_e;

    localparam int unsigned TIME_TICK_DEFAULT = 10000;

    // A programmed length of 0 behaves like 1, so the final unit index is max(len,1)-1.
    function automatic logic [15:0] lastUnit(input logic [15:0] len);
        return (len == 16'd0) ? 16'd0 : len - 16'd1;
    endfunction

endpackage

// File: rtl/led_driver_tick_gen.sv
// Time-unit prescaler: counts 0..TIME_TICK-1 and flags the last count as a tick.
// Kept standalone so input-side filters can reuse the same time base.
module tick_gen
    import led_driver_pkg::*;
#(
    parameter int unsigned TIME_TICK = TIME_TICK_DEFAULT
) (
    input  logic clk,
    input  logic res_n,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TIME_TICK - 1);

    logic [15:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= 16'd0;
        end else if (clr || tick) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/led_driver.sv
// LED output driver with static, blink and pulse-stretch modes plus a
// combinational bypass when disabled.
module led_driver
    import led_driver_pkg::*;
#(
    parameter int unsigned TIME_TICK = TIME_TICK_DEFAULT
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        ena,
    input  logic [1:0]  mode,
    input  logic [15:0] on_time,
    input  logic [15:0] off_time,
    input  logic        data_in,
    output logic        data_out,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] unitCnt_q;
    logic [1:0]  modePrev_q;
    logic        prevIn_q;
    logic        armed_q;
    logic        dataOut_q;
    logic        busy_q;

    logic        tick;
    logic        clr;
    logic        isStatic;
    logic        modeChg;
    logic        rise;
    logic        phaseEnd;
    logic        entry;

    assign isStatic = (mode == MODE_STATIC) || (mode == MODE_RESERVED);
    assign modeChg  = (mode != modePrev_q);
    // armed_q masks the first sample after reset so a level held through reset is not seen as an edge.
    assign rise     = armed_q && data_in && !prevIn_q;
    assign phaseEnd = tick && (unitCnt_q == lastUnit(len_q));

    always_comb begin
        state_d = state_q;
        if (!ena || isStatic) begin
            state_d = ST_IDLE;
        end else if (modeChg) begin
            state_d = ((mode == MODE_STRETCH) && rise) ? ST_ON : ST_IDLE;
        end else if (mode == MODE_BLINK) begin
            case (state_q)
                ST_IDLE: if (data_in) state_d = ST_ON;
                ST_ON: begin
                    if (!data_in)      state_d = ST_IDLE;
                    else if (phaseEnd) state_d = ST_OFF;
                end
                ST_OFF: begin
                    if (!data_in)      state_d = ST_IDLE;
                    else if (phaseEnd) state_d = ST_ON;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: if (rise) state_d = ST_ON;
                ST_ON:   if (phaseEnd) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Phase lengths are latched only on entry so mid-phase edits apply to the next phase.
    always_comb begin
        entry = (state_d != state_q) || modeChg;
        len_d = len_q;
        if (entry && (state_d == ST_ON))  len_d = on_time;
        if (entry && (state_d == ST_OFF)) len_d = off_time;
        clr   = entry || (state_d == ST_IDLE);
    end

    tick_gen #(
        .TIME_TICK (TIME_TICK)
    ) u_tick_gen (
        .clk   (clk),
        .res_n (res_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= ST_IDLE;
            len_q      <= 16'd0;
            unitCnt_q  <= 16'd0;
            modePrev_q <= MODE_STATIC;
            prevIn_q   <= 1'b0;
            armed_q    <= 1'b0;
            dataOut_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            if (clr) begin
                unitCnt_q <= 16'd0;
            end else if (tick) begin
                unitCnt_q <= unitCnt_q + 16'd1;
            end
            modePrev_q <= mode;
            prevIn_q   <= data_in;
            armed_q    <= 1'b1;
            dataOut_q  <= isStatic ? data_in : (state_d == ST_ON);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign data_out = ena ? dataOut_q : data_in;
    assign busy     = busy_q;

endmodule

// File: tb/tb_led_driver.sv
// Scoreboard bench for led_driver: a phase-countdown reference model predicts
// every cycle's outputs, and a monitor compares them one cycle at a time.
module tb_led_driver;

    localparam int TT = 10;

    typedef struct packed {
        logic dout;
        logic busy;
    } exp_t;

    logic        clk;
    logic        res_n;
    logic        ena;
    logic [1:0]  mode;
    logic [15:0] on_time;
    logic [15:0] off_time;
    logic        data_in;
    logic        data_out;
    logic        busy;

    exp_t expQ[$];
    int   vectors;
    int   fails;
    int   highCnt;

    // reference model: phase tracked as a countdown of remaining clock cycles
    int          mSt;
    int          mRem;
    logic        mPrevIn;
    logic        mArmed;
    logic        mRegOut;
    logic [1:0]  mPrevMode;

    localparam int M_IDLE = 0;
    localparam int M_ON   = 1;
    localparam int M_OFF  = 2;

    led_driver #(
        .TIME_TICK (TT)
    ) dut (
        .clk      (clk),
        .res_n    (res_n),
        .ena      (ena),
        .mode     (mode),
        .on_time  (on_time),
        .off_time (off_time),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int phaseCycles(input logic [15:0] len);
        return ((len == 16'd0) ? 1 : int'(len)) * TT;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic modelStep();
        int   nxt;
        logic stat;
        logic rise;
        logic entered;
        exp_t e;
        if (!res_n) begin
            mSt = M_IDLE; mRem = 0; mPrevIn = 1'b0; mArmed = 1'b0;
            mRegOut = 1'b0; mPrevMode = 2'b00;
        end else begin
            stat    = (mode == 2'b00) || (mode == 2'b11);
            rise    = mArmed && data_in && !mPrevIn;
            nxt     = mSt;
            entered = 1'b0;
            if (!ena || stat) begin
                nxt = M_IDLE;
            end else if (mode != mPrevMode) begin
                nxt = M_IDLE;
                if (mode == 2'b10 && rise) begin nxt = M_ON; entered = 1'b1; end
            end else if (mode == 2'b01) begin
                if (mSt == M_IDLE) begin
                    if (data_in) begin nxt = M_ON; entered = 1'b1; end
                end else if (!data_in) begin
                    nxt = M_IDLE;
                end else if (mRem == 1) begin
                    nxt = (mSt == M_ON) ? M_OFF : M_ON;
                    entered = 1'b1;
                end
            end else begin
                if (mSt == M_IDLE && rise) begin
                    nxt = M_ON; entered = 1'b1;
                end else if (mSt == M_ON && mRem == 1) begin
                    nxt = M_IDLE;
                end
            end
            if (entered) mRem = phaseCycles((nxt == M_ON) ? on_time : off_time);
            else if (nxt != M_IDLE) mRem = mRem - 1;
            mSt       = nxt;
            mRegOut   = stat ? data_in : (nxt == M_ON);
            mPrevIn   = data_in;
            mArmed    = 1'b1;
            mPrevMode = mode;
        end
        e.dout = ena ? mRegOut : data_in;
        e.busy = (mSt != M_IDLE);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic [15:0] on, input logic [15:0] off,
                                 input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            res_n = r; ena = e; mode = m; on_time = on; off_time = off; data_in = d;
            modelStep();
        end
    endtask

    task automatic asyncReset();
        @(negedge clk);
        res_n = 1'b0;
        #1;
        checkOutput("asyncDataOut", int'(data_out), ena ? 0 : int'(data_in));
        checkOutput("asyncBusy", int'(busy), 0);
        modelStep();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (data_out === 1'b1) highCnt++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("data_out", int'(data_out), int'(e.dout));
                checkOutput("busy", int'(busy), int'(e.busy));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        logic        e;
        logic [1:0]  m;
        logic [15:0] on;
        logic [15:0] off;
        logic        d;
        int          n;
        vectors = 0; fails = 0; highCnt = 0;
        res_n = 1'b0; ena = 1'b1; mode = 2'b00; on_time = 16'd0; off_time = 16'd0; data_in = 1'b0;

        // reset, then a stretched pulse from a two-cycle request
        applyStimulus(0, 1, 2'b00, 0, 0, 0, 3);
        applyStimulus(1, 1, 2'b10, 3, 0, 0, 3);
        highCnt = 0;
        applyStimulus(1, 1, 2'b10, 3, 0, 1, 2);
        applyStimulus(1, 1, 2'b10, 3, 0, 0, 36);
        checkOutput("stretchWidth", highCnt, 3 * TT);

        // zero length behaves as one unit; second edge inside the pulse ignored
        applyStimulus(1, 1, 2'b10, 0, 0, 0, 2);
        highCnt = 0;
        applyStimulus(1, 1, 2'b10, 0, 0, 1, 3);
        applyStimulus(1, 1, 2'b10, 0, 0, 0, 2);
        applyStimulus(1, 1, 2'b10, 0, 0, 1, 2);
        applyStimulus(1, 1, 2'b10, 0, 0, 0, 12);
        checkOutput("zeroLenWidth", highCnt, TT);

        // blink 20/10, then drop the request mid-ON
        applyStimulus(1, 1, 2'b01, 2, 1, 1, 75);
        applyStimulus(1, 1, 2'b01, 2, 1, 0, 4);

        // bypass toggling, then disable mid-blink
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 2'b01, 2, 1, 1'(i % 2), 1);
        applyStimulus(1, 1, 2'b01, 2, 1, 1, 6);
        applyStimulus(1, 0, 2'b01, 2, 1, 1, 3);
        applyStimulus(1, 0, 2'b01, 2, 1, 0, 2);

        // reset mid-pulse, request held through reset must not retrigger
        applyStimulus(1, 1, 2'b10, 3, 0, 0, 3);
        applyStimulus(1, 1, 2'b10, 3, 0, 1, 5);
        asyncReset();
        applyStimulus(0, 1, 2'b10, 3, 0, 1, 2);
        highCnt = 0;
        applyStimulus(1, 1, 2'b10, 3, 0, 1, 40);
        checkOutput("noStalePulse", highCnt, 0);
        applyStimulus(1, 1, 2'b10, 3, 0, 0, 2);
        highCnt = 0;
        applyStimulus(1, 1, 2'b10, 3, 0, 1, 3);
        applyStimulus(1, 1, 2'b10, 3, 0, 0, 35);
        checkOutput("freshEdgeWidth", highCnt, 3 * TT);

        // mode change to static while blinking in OFF
        applyStimulus(1, 1, 2'b01, 1, 3, 1, 15);
        applyStimulus(1, 1, 2'b00, 1, 3, 1, 1);
        applyStimulus(1, 1, 2'b00, 1, 3, 0, 2);
        applyStimulus(1, 1, 2'b00, 1, 3, 1, 2);

        // randomized segments including mid-phase length edits and rare resets
        d = 1'b0;
        for (int s = 0; s < 60; s++) begin
            e   = ($urandom_range(0, 9) != 0);
            m   = 2'($urandom_range(0, 3));
            on  = 16'($urandom_range(0, 3));
            off = 16'($urandom_range(0, 3));
            n   = $urandom_range(1, 30);
            if ($urandom_range(0, 19) == 0) asyncReset();
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 5) == 0) d = ~d;
                applyStimulus(1, e, m, on, off, d, 1);
            end
        end

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
